// File: rtl/seven_segment_scan_controller.sv
// Scans a double-buffered BCD word across common-anode digits through
// one shared decoder, with per-slot dead time and leading-zero blanking.
module seven_segment_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 50000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_digits,
    output logic [3:0]              digit_num,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [SW-1:0]           slot;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;

    logic                    slot_end;
    logic                    frame_end;
    logic                    dead;
    logic                    take;
    logic                    commit;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   zero_tail;
    logic [NUM_DIGITS-1:0]   drive_mask;
    logic [3:0]              eff_code;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = enable && slot_end && (slot == SLOT_LAST);
    assign dead      = (32'(cnt) < 32'(DEAD_CYCLES));
    assign take      = load_valid && load_ready;
    // While frozen there is no frame boundary to wait for.
    assign commit    = !load_ready && (frame_end || !enable);

    // zero_tail[i]: digits NUM_DIGITS-1 down to i are all zero
    always_comb begin
        zero_run  = 1'b1;
        zero_tail = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (active[4*i +: 4] == 4'h0);
            zero_tail[i] = zero_run;
        end
    end

    always_comb begin
        eff_code   = 4'hF;
        drive_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SW'(i)) begin
                drive_mask[i] = 1'b1;
                if (blank_lz && zero_tail[i] && (i != 0))
                    eff_code = 4'hF;
                else
                    eff_code = active[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            slot <= '0;
        end else if (enable) begin
            cnt <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                slot <= (slot == SLOT_LAST) ? '0 : slot + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= '1;
            pending    <= '1;
            load_ready <= 1'b1;
        end else begin
            if (commit)
                active <= pending;
            if (take) begin
                pending    <= load_digits;
                load_ready <= 1'b0;
            end else if (commit) begin
                load_ready <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_num  <= 4'hF;
            anodes     <= '1;
            frame_done <= 1'b0;
        end else begin
            if (enable && dead)
                digit_num <= eff_code;
            anodes     <= (enable && !dead) ? ~drive_mask : '1;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed scoreboard bench for seven_segment_scan_controller
// (4 digits, 8-cycle slots, 2 dead cycles).
module tb_seven_segment_scan_controller;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        blank_lz;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_digits;
    logic [3:0]  digit_num;
    logic [3:0]  anodes;
    logic        frame_done;

    seven_segment_scan_controller #(
        .NUM_DIGITS (4),
        .PRESCALE   (8),
        .DEAD_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_digits(load_digits),
        .digit_num  (digit_num),
        .anodes     (anodes),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [3:0] dn;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t        sb[$];
    int          ncmp = 0;
    int          nerr = 0;

    // expected-behaviour state
    int          s_slot;
    int          s_p;
    logic [15:0] codes;
    logic [15:0] next_codes;
    logic [3:0]  exp_dn;
    logic        exp_ready;
    logic        load_armed;
    int          ld_slot;
    int          ld_p;
    logic [15:0] ld_data;
    string       phase;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        logic bnd;
        logic r;
        logic inj;
        logic cm;
        cm  = 1'b0;
        inj = load_armed && (s_slot == ld_slot) && (s_p == ld_p);
        if (inj) begin
            load_valid  = 1'b1;
            load_digits = ld_data;
        end
        bnd = enable && (s_p == 7) && (s_slot == 3);
        r   = exp_ready;
        if (load_valid && exp_ready) begin
            r = 1'b0;
        end else if (!exp_ready && (bnd || !enable)) begin
            r  = 1'b1;
            cm = 1'b1;
        end
        if (enable) begin
            e.an = (s_p < 2) ? 4'hF : ~(4'b0001 << s_slot);
            if (s_p < 2)
                exp_dn = codes[4*s_slot +: 4];
        end else begin
            e.an = 4'hF;
        end
        e.dn  = exp_dn;
        e.fd  = bnd;
        e.rdy = r;
        e.tag = $sformatf("%s_s%0d_p%0d", phase, s_slot, s_p);
        sb.push_back(e);
        if (cm)
            codes = next_codes;
        if (enable) begin
            if (s_p == 7) begin
                s_p    = 0;
                s_slot = (s_slot == 3) ? 0 : s_slot + 1;
            end else begin
                s_p++;
            end
        end
        exp_ready = r;
        @(posedge clk);
        @(negedge clk);
        if (inj) begin
            load_valid = 1'b0;
            load_armed = 1'b0;
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_an"}, 16'(anodes), 16'(e.an));
            chk({e.tag, "_dn"}, 16'(digit_num), 16'(e.dn));
            chk({e.tag, "_fd"}, 16'(frame_done), 16'(e.fd));
            chk({e.tag, "_rdy"}, 16'(load_ready), 16'(e.rdy));
        end
    endtask

    task automatic tick_until(int ts, int tp);
        int n;
        n = 0;
        while (!((s_slot == ts) && (s_p == tp))) begin
            if (n >= 200) begin
                ncmp++;
                nerr++;
                $error("FAIL %s_timeout: got %0d ticks expected <200",
                       phase, n);
                break;
            end
            tick();
            n++;
        end
    endtask

    task automatic run_frame(string nm, logic blk, logic [15:0] cur,
                             logic [15:0] nxt, logic ld,
                             logic [15:0] data);
        phase      = nm;
        blank_lz   = blk;
        codes      = cur;
        next_codes = nxt;
        if (ld) begin
            load_armed = 1'b1;
            ld_slot    = 1;
            ld_p       = 3;
            ld_data    = data;
        end
        repeat (32) tick();
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        blank_lz    = 1'b0;
        load_valid  = 1'b0;
        load_digits = 16'h0;
        load_armed  = 1'b0;
        ld_slot     = 0;
        ld_p        = 0;
        ld_data     = 16'h0;
        phase       = "rst";
        repeat (2) @(negedge clk);
        chk("rst_an", 16'(anodes), 16'hF);
        chk("rst_dn", 16'(digit_num), 16'hF);
        chk("rst_fd", 16'(frame_done), 16'h0);
        chk("rst_rdy", 16'(load_ready), 16'h1);

        s_slot     = 0;
        s_p        = 0;
        codes      = 16'hFFFF;
        next_codes = 16'hFFFF;
        exp_dn     = 4'hF;
        exp_ready  = 1'b1;
        enable     = 1'b1;
        reset_n    = 1'b1;

        // blank display, then plain load, then blanking variants
        run_frame("f0_idle", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);
        run_frame("f1_ld", 1'b0, 16'hFFFF, 16'h1234, 1'b1, 16'h1234);
        run_frame("f2_1234", 1'b0, 16'h1234, 16'h0007, 1'b1, 16'h0007);
        run_frame("f3_lz7", 1'b1, 16'hFFF7, 16'h0007, 1'b1, 16'h0007);
        run_frame("f4_7", 1'b0, 16'h0007, 16'h0000, 1'b1, 16'h0000);
        run_frame("f5_lz0", 1'b1, 16'hFFF0, 16'h0000, 1'b0, 16'h0);

        // load_valid held with changing data for a whole frame
        phase      = "f6_hold";
        blank_lz   = 1'b0;
        codes      = 16'h0000;
        next_codes = 16'h9821;
        for (int i = 0; i < 32; i++) begin
            load_valid  = 1'b1;
            load_digits = 16'h9800 | 16'(8'(8'h21 + i));
            tick();
        end
        load_valid = 1'b0;
        run_frame("f7_9821", 1'b0, 16'h9821, 16'h9821, 1'b0, 16'h0);

        // freeze mid slot 2 with a pending value
        phase      = "f8_pre";
        codes      = 16'h9821;
        next_codes = 16'h5555;
        load_armed = 1'b1;
        ld_slot    = 1;
        ld_p       = 3;
        ld_data    = 16'h5555;
        tick_until(2, 4);
        phase  = "f8_off";
        enable = 1'b0;
        repeat (3) tick();
        phase  = "f8_on";
        enable = 1'b1;
        tick_until(0, 0);

        // async reset mid DRIVE with a pending value
        phase      = "f9_pre";
        codes      = 16'h5555;
        next_codes = 16'h6666;
        load_armed = 1'b1;
        ld_slot    = 1;
        ld_p       = 3;
        ld_data    = 16'h6666;
        tick_until(2, 5);
        reset_n = 1'b0;
        #1;
        chk("arst_an", 16'(anodes), 16'hF);
        chk("arst_dn", 16'(digit_num), 16'hF);
        chk("arst_fd", 16'(frame_done), 16'h0);
        chk("arst_rdy", 16'(load_ready), 16'h1);
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_an", 16'(anodes), 16'hF);
        load_armed = 1'b0;
        s_slot     = 0;
        s_p        = 0;
        exp_dn     = 4'hF;
        exp_ready  = 1'b1;
        reset_n    = 1'b1;
        run_frame("f10_post", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);
        run_frame("f11_post", 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nerr);
        $finish;
    end

endmodule
